pipeline_stage_regs: RTL

PIPELINE_STAGE_REGS -- requirements
Module: pipeline_stage_regs

---
 rtl/pipeline_stage_regs.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/pipeline_stage_regs.sv
// rtl/pipeline_stage_regs.sv - PC, IF/ID and ID/EX pipeline registers with hazard control
//
// Purpose: holds the fetch PC and the two front-end pipeline registers of a
// five-stage RISC-V style core. Each register follows the priority
// reset > flush > stall > load. It also keeps two saturating event counters
// for stalls and flushes.
//
// Ports:
//   clk, reset_n                 clock, synchronous active-low reset
//   StallF, StallD               hold the PC / IF/ID register
//   FlushD, FlushE               bubble the IF/ID / ID/EX register
//   PCSrcE, PCTargetE            redirect the PC to the E-stage target
//   InstrF                       fetched instruction
//   RD1D, RD2D, ImmExtD          decode-stage operands and immediate
//   Rs1D, Rs2D, RdD, CtrlD       decode-stage register indices and control bundle
//   PCF, PCPlus4F                fetch PC and its successor (successor is combinational)
//   InstrD, PCD, PCPlus4D, ValidD                IF/ID contents
//   RD1E, RD2E, ImmExtE, PCE, PCPlus4E,
//   Rs1E, Rs2E, RdE, CtrlE, ValidE               ID/EX contents
//   StallCount, FlushCount       saturating event counters

module pipeline_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Counting stops at all-ones so a long stall never reads back as a small number.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

module pipeline_stage_regs #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        FlushE,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic [31:0] InstrF,
  input  logic [31:0] RD1D,
  input  logic [31:0] RD2D,
  input  logic [31:0] ImmExtD,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  RdD,
  input  logic [9:0]  CtrlD,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic [31:0] RD1E,
  output logic [31:0] RD2E,
  output logic [31:0] ImmExtE,
  output logic [31:0] PCE,
  output logic [31:0] PCPlus4E,
  output logic [4:0]  Rs1E,
  output logic [4:0]  Rs2E,
  output logic [4:0]  RdE,
  output logic [9:0]  CtrlE,
  output logic        ValidE,
  output logic [15:0] StallCount,
  output logic [15:0] FlushCount
);

  logic [31:0] pc_next;

  // Wraps modulo 2^32 by construction of the 32-bit add.
  assign PCPlus4F = PCF + 32'd4;

  // The redirect is only consulted when the PC is allowed to advance.
  always_comb begin
    pc_next = PCPlus4F;
    if (PCSrcE) begin
      pc_next = PCTargetE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      PCF <= RESET_PC;
    end else if (!StallF) begin
      PCF <= pc_next;
    end
  end

  // IF/ID: a flush wins over a simultaneous stall so a squashed instruction
  // cannot linger in decode.
  always_ff @(posedge clk) begin
    if (!reset_n || FlushD) begin
      InstrD   <= NOP_INSTR;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (!StallD) begin
      InstrD   <= InstrF;
      PCD      <= PCF;
      PCPlus4D <= PCPlus4F;
      ValidD   <= 1'b1;
    end
  end

  // ID/EX: no stall input. A flush clears the control bundle so the bubble
  // cannot write a register, write memory, branch or jump.
  always_ff @(posedge clk) begin
    if (!reset_n || FlushE) begin
      RD1E     <= '0;
      RD2E     <= '0;
      ImmExtE  <= '0;
      PCE      <= '0;
      PCPlus4E <= '0;
      Rs1E     <= '0;
      Rs2E     <= '0;
      RdE      <= '0;
      CtrlE    <= '0;
      ValidE   <= 1'b0;
    end else begin
      RD1E     <= RD1D;
      RD2E     <= RD2D;
      ImmExtE  <= ImmExtD;
      PCE      <= PCD;
      PCPlus4E <= PCPlus4D;
      Rs1E     <= Rs1D;
      Rs2E     <= Rs2D;
      RdE      <= RdD;
      CtrlE    <= CtrlD;
      ValidE   <= ValidD;
    end
  end

  pipeline_sat_counter #(.W(16)) u_stall_count (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (StallD),
    .count   (StallCount)
  );

  pipeline_sat_counter #(.W(16)) u_flush_count (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (FlushD | FlushE),
    .count   (FlushCount)
  );

endmodule
